// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory line port between I-side fills and D-side fills/write-backs
module mem_port_arbiter #(
    parameter int LINE_BITS = 128,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_ack,
    output logic [LINE_BITS-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic                 d_ack,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 timeout_err
);
    localparam int OFFS = $clog2(LINE_BITS / 8);
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_e;

    state_e               state_q, state_d;
    logic                 last_d_q, last_d_d;   // 1: data side holds (or last held) the port
    logic [31:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 terr_q, terr_d;
    logic [LINE_BITS-1:0] irdata_q, irdata_d;
    logic [LINE_BITS-1:0] drdata_q, drdata_d;

    logic                 pick_d;
    logic [CW-1:0]        cnt_inc;
    logic [LINE_BITS-1:0] fill_line;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        irdata_d  = irdata_q;
        drdata_d  = drdata_q;
        pick_d    = 1'b0;
        cnt_inc   = cnt_q + CW'(1);
        fill_line = '0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // Under contention the side that did not win last time goes first
                    pick_d             = d_req && (!i_req || !last_d_q);
                    last_d_d           = pick_d;
                    addr_d             = pick_d ? d_addr : i_addr;
                    addr_d[OFFS-1:0]   = '0;
                    we_d               = pick_d && d_we;
                    wdata_d            = (pick_d && d_we) ? d_wdata : '0;
                    state_d            = MEM;
                end
            end
            MEM: begin
                cnt_d = cnt_inc;
                if (mem_ready || cnt_inc == TO_LAST) begin
                    fill_line = mem_ready ? mem_rdata : '0;
                    if (!mem_ready) begin
                        terr_d = 1'b1;
                    end
                    if (!we_q) begin
                        if (last_d_q) begin
                            drdata_d = fill_line;
                        end else begin
                            irdata_d = fill_line;
                        end
                    end
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == MEM);
        i_ack   = (state_q == RESP) && !last_d_q;
        d_ack   = (state_q == RESP) && last_d_q;
    end

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_rdata     = irdata_q;
    assign d_rdata     = drdata_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int LB = 128;
    localparam int TO = 8;

    logic          clock, reset;
    logic          i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0]   i_addr, d_addr, mem_addr;
    logic [LB-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, mem_ready, timeout_err;

    mem_port_arbiter #(.LINE_BITS(LB), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Requesters: raise req while work is pending, drop it at the edge ending the ack cycle
    int   i_pending = 0, i_done = 0, d_pending = 0, d_done = 0;
    logic ia_s, da_s;

    initial begin
        i_req = 1'b0;
        forever begin
            @(negedge clock); ia_s = i_ack;
            @(posedge clock); #1;
            if (!reset) begin
                i_done = i_pending; i_req = 1'b0;
            end else begin
                if (i_req && ia_s) i_done++;
                i_req = (i_done != i_pending);
            end
        end
    end

    initial begin
        d_req = 1'b0;
        forever begin
            @(negedge clock); da_s = d_ack;
            @(posedge clock); #1;
            if (!reset) begin
                d_done = d_pending; d_req = 1'b0;
            end else begin
                if (d_req && da_s) d_done++;
                d_req = (d_done != d_pending);
            end
        end
    end

    // Memory responder: ready on the mem_lat-th mem_req cycle (0 = never)
    int            mem_lat = 1;
    int            mcnt = 0;
    logic          spurious = 1'b0;
    logic [LB-1:0] mem_line = '0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            if (mem_req) begin
                mcnt++;
                mem_ready = (mem_lat != 0) && (mcnt == mem_lat);
            end else begin
                mcnt = 0;
                mem_ready = spurious;
            end
            mem_rdata = mem_ready ? mem_line : ~mem_line;
        end
    end

    // Transaction-level reference: one transfer in flight, its age, and who owns it
    bit            m_active = 0, m_resp = 0, m_owner_d = 0, m_last_d = 0, m_we = 0, m_terr = 0;
    int            m_age = 0;
    logic [31:0]   m_addr = '0;
    logic [LB-1:0] m_wdata = '0, m_irdata = '0, m_drdata = '0;

    task automatic model_step();
        if (!reset) begin
            m_active = 0; m_resp = 0; m_owner_d = 0; m_last_d = 0; m_we = 0; m_terr = 0;
            m_age = 0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
            return;
        end
        if (!m_active) begin
            if (i_req || d_req) begin
                if (i_req && d_req) m_owner_d = !m_last_d;
                else                m_owner_d = d_req;
                m_last_d = m_owner_d;
                m_addr   = (m_owner_d ? d_addr : i_addr) & ~32'(LB / 8 - 1);
                m_we     = m_owner_d && d_we;
                m_wdata  = m_we ? d_wdata : '0;
                m_active = 1; m_resp = 0; m_age = 0;
            end
        end else if (!m_resp) begin
            m_age++;
            if (mem_ready || m_age == TO) begin
                m_resp = 1;
                if (!mem_ready) m_terr = 1;
                if (!m_we) begin
                    if (m_owner_d) m_drdata = mem_ready ? mem_rdata : '0;
                    else           m_irdata = mem_ready ? mem_rdata : '0;
                end
            end
        end else begin
            m_active = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            model_step();
        end
    end

    // Per-cycle compare plus logs of grants/acks for the literal checks
    bit          ack_log[$];
    logic [31:0] addr_log[$];
    logic        we_log[$];
    logic [LB-1:0] wd_log[$];
    int          cur_burst = 0, last_burst = 0;
    logic        prev_req = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            check("mem_req",     LB'(mem_req),     LB'(m_active && !m_resp));
            check("i_ack",       LB'(i_ack),       LB'(m_active && m_resp && !m_owner_d));
            check("d_ack",       LB'(d_ack),       LB'(m_active && m_resp && m_owner_d));
            check("mem_we",      LB'(mem_we),      LB'(m_we));
            check("mem_addr",    LB'(mem_addr),    LB'(m_addr));
            check("mem_wdata",   mem_wdata,        m_wdata);
            check("i_rdata",     i_rdata,          m_irdata);
            check("d_rdata",     d_rdata,          m_drdata);
            check("timeout_err", LB'(timeout_err), LB'(m_terr));
            if (mem_req && !prev_req) begin
                addr_log.push_back(mem_addr); we_log.push_back(mem_we); wd_log.push_back(mem_wdata);
            end
            if (mem_req) cur_burst++;
            else if (prev_req) begin last_burst = cur_burst; cur_burst = 0; end
            if (i_ack) ack_log.push_back(1'b0);
            if (d_ack) ack_log.push_back(1'b1);
            prev_req = mem_req;
        end
    end

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (i_done == i_pending && d_done == d_pending) begin ok = 1; break; end
            @(posedge clock); #2;
        end
        check(name, LB'(ok), LB'(1));
    endtask

    task automatic start_cycle();
        @(posedge clock); #3;
    endtask

    int ab, aa;
    localparam logic [LB-1:0] L1 = {4{32'hDEADBEEF}};
    localparam logic [LB-1:0] LA = {16{8'hA5}};
    localparam logic [LB-1:0] LS = {8{16'h5A3C}};
    localparam logic [LB-1:0] LW = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [LB-1:0] L2 = {4{32'h0BADF00D}};
    localparam logic [LB-1:0] L3 = {4{32'h600DCAFE}};

    initial begin
        reset = 1'b0;
        i_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_req", LB'(mem_req), LB'(0));
        check("rst_terr",    LB'(timeout_err), LB'(0));
        check("rst_i_rdata", i_rdata, '0);
        #1 reset = 1'b1;

        // Contention after reset: D first, then I
        start_cycle();
        ab = ack_log.size(); aa = addr_log.size();
        mem_lat = 1; mem_line = L1;
        i_addr = 32'h0000_2008; d_addr = 32'h0000_3010; d_we = 1'b0;
        i_pending++; d_pending++;
        wait_done("contend_done");
        check("contend_nacks", LB'(ack_log.size() - ab), LB'(2));
        check("contend_first_d", LB'(ack_log[ab]), LB'(1));
        check("contend_second_i", LB'(ack_log[ab+1]), LB'(0));
        check("contend_addr0", LB'(addr_log[aa]), LB'(32'h0000_3010));
        check("contend_addr1", LB'(addr_log[aa+1]), LB'(32'h0000_2000));
        check("contend_i_rdata", i_rdata, L1);

        // Single fill, 3-cycle memory
        start_cycle();
        ab = ack_log.size(); aa = addr_log.size();
        mem_lat = 3; mem_line = LA; i_addr = 32'h0000_1234;
        i_pending++;
        wait_done("fill_done");
        check("fill_addr", LB'(addr_log[aa]), LB'(32'h0000_1230));
        check("fill_we", LB'(we_log[aa]), LB'(0));
        check("fill_burst", LB'(last_burst), LB'(3));
        check("fill_one_ack", LB'(ack_log.size() - ab), LB'(1));
        check("fill_ack_is_i", LB'(ack_log[ab]), LB'(0));
        check("fill_i_rdata", i_rdata, LA);

        // Sustained contention: strict alternation starting with D
        start_cycle();
        ab = ack_log.size();
        mem_lat = 1; mem_line = LS;
        i_pending += 3; d_pending += 3;
        wait_done("sustain_done");
        check("sustain_nacks", LB'(ack_log.size() - ab), LB'(6));
        for (int k = 0; k < 6; k++)
            check($sformatf("sustain_grant%0d", k), LB'(ack_log[ab+k]), LB'((k % 2) == 0));

        // Stray mem_ready while idle must be ignored
        start_cycle();
        spurious = 1'b1;
        repeat (3) @(posedge clock);
        #3 spurious = 1'b0;
        check("spurious_terr", LB'(timeout_err), LB'(0));

        // Write-back leaves d_rdata alone
        start_cycle();
        ab = ack_log.size(); aa = addr_log.size();
        mem_lat = 2; mem_line = L2;
        d_we = 1'b1; d_addr = 32'h8000_0040; d_wdata = LW;
        d_pending++;
        wait_done("wb_done");
        check("wb_we", LB'(we_log[aa]), LB'(1));
        check("wb_wdata", wd_log[aa], LW);
        check("wb_addr", LB'(addr_log[aa]), LB'(32'h8000_0040));
        check("wb_ack_d", LB'(ack_log[ab]), LB'(1));
        check("wb_d_rdata", d_rdata, LS);
        d_we = 1'b0;

        // Timeout: memory never answers
        start_cycle();
        ab = ack_log.size();
        mem_lat = 0; d_addr = 32'h0000_0100;
        d_pending++;
        wait_done("to_done");
        check("to_burst", LB'(last_burst), LB'(8));
        check("to_terr", LB'(timeout_err), LB'(1));
        check("to_d_rdata", d_rdata, '0);
        check("to_ack_d", LB'(ack_log[ab]), LB'(1));

        // Next request served normally, error stays sticky
        start_cycle();
        mem_lat = 2; mem_line = L2; i_addr = 32'h0000_0400;
        i_pending++;
        wait_done("after_to_done");
        check("after_to_i_rdata", i_rdata, L2);
        check("after_to_terr", LB'(timeout_err), LB'(1));

        // Reset in the middle of a transfer
        start_cycle();
        mem_lat = 0; d_addr = 32'h0000_0200;
        d_pending++;
        begin
            bit seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                if (mem_req) begin seen = 1; break; end
            end
            check("mid_mem_req_seen", LB'(seen), LB'(1));
        end
        @(posedge clock); #2 reset = 1'b0;
        #1;
        check("mid_mem_req", LB'(mem_req), LB'(0));
        check("mid_d_ack", LB'(d_ack), LB'(0));
        check("mid_i_ack", LB'(i_ack), LB'(0));
        check("mid_terr", LB'(timeout_err), LB'(0));
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;

        start_cycle();
        ab = ack_log.size();
        mem_lat = 1; mem_line = L3;
        i_addr = 32'h0000_0500; d_addr = 32'h0000_0600;
        i_pending++; d_pending++;
        wait_done("post_rst_done");
        check("post_rst_first_d", LB'(ack_log[ab]), LB'(1));
        check("post_rst_second_i", LB'(ack_log[ab+1]), LB'(0));
        check("post_rst_d_rdata", d_rdata, L3);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
